wr_port_arb: RTL

WR_PORT_ARB -- requirements
Module: wr_port_arb

---
 rtl/wr_port_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wr_port_arb.sv
// wr_port_arb
// Round-robin arbiter that picks up to N_WRITE_PORTS write requests per cycle
// from N_REQ requesters and registers them onto the write ports of a
// multi-ported RAM-FIFO. Two requests to the same entry are never granted in
// the same cycle, so the RAM never sees colliding writes.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   stall      suppresses all grants this cycle
//   req_valid  per-requester write request
//   req_addr   per-requester target entry
//   req_data   per-requester payload
//   req_ready  combinational grant (transfer = valid & ready)
//   wr_en      registered per-port write enable
//   wr_addr    registered per-port write address
//   wr_data    registered per-port write data
//   rr_ptr     current round-robin start index (debug)
module wr_port_arb #(
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_ENTRIES     = 8,
  parameter int N_REQ         = 4,
  parameter int N_WRITE_PORTS = 2,
  localparam int PTR_WIDTH    = $clog2(N_ENTRIES),
  localparam int REQ_IDX_W    = $clog2(N_REQ)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       stall,
  input  logic [N_REQ-1:0]                           req_valid,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0]            req_addr,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]          req_data,
  output logic [N_REQ-1:0]                           req_ready,
  output logic [N_WRITE_PORTS-1:0]                   wr_en,
  output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr,
  output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data,
  output logic [REQ_IDX_W-1:0]                       rr_ptr
);

  logic [REQ_IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [N_WRITE_PORTS-1:0]                   wr_en_q, wr_en_d;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic [N_REQ-1:0]                           grant;
  logic [N_WRITE_PORTS-1:0]                   port_used;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    port_addr;
  logic [N_WRITE_PORTS-1:0][REQ_IDX_W-1:0]    port_src;
  logic [REQ_IDX_W-1:0]                       last_idx;
  logic                                       any_grant;

  // Grant scan. Only valid/addr/stall/rst/rr_ptr feed this block, so the
  // ready path never depends on payload data. A request that collides with an
  // address already granted this cycle is skipped without using up a port.
  // N_REQ is a power of two, so the rr_ptr + j wrap is plain truncation.
  always_comb begin : scan
    logic [REQ_IDX_W-1:0] idx;
    logic                 conflict;
    int                   n_grant;
    grant     = '0;
    port_used = '0;
    port_addr = '0;
    port_src  = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    idx       = '0;
    conflict  = 1'b0;
    n_grant   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      idx      = rr_ptr_q + REQ_IDX_W'(j);
      conflict = 1'b0;
      for (int k = 0; k < N_WRITE_PORTS; k++) begin
        if (port_used[k] && (port_addr[k] == req_addr[idx])) conflict = 1'b1;
      end
      if (req_valid[idx] && !stall && !rst && (n_grant < N_WRITE_PORTS) && !conflict) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < N_WRITE_PORTS; k++) begin
          if (k == n_grant) begin
            port_used[k] = 1'b1;
            port_addr[k] = req_addr[idx];
            port_src[k]  = idx;
          end
        end
        n_grant   = n_grant + 1;
        last_idx  = idx;
        any_grant = 1'b1;
      end
    end
  end

  // Next-state for the write ports and the round-robin pointer. Ports beyond
  // the number of grants stay fully zeroed rather than holding stale data.
  always_comb begin : next_state
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int k = 0; k < N_WRITE_PORTS; k++) begin
      if (port_used[k]) begin
        wr_en_d[k]   = 1'b1;
        wr_addr_d[k] = port_addr[k];
        wr_data_d[k] = req_data[port_src[k]];
      end
    end
    if (any_grant) rr_ptr_d = last_idx + REQ_IDX_W'(1);
  end

  // State registers; reset wins over any grant taken in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req_ready = grant;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rr_ptr    = rr_ptr_q;

endmodule
